uart_tx_sched: RTL

Shares one serial transmit line between `NREQ` byte requesters. It round-robin arbitrates pending requests, latches the winner's byte, and serialises it as an 8N1 frame (start, data LSB-first, stop). Bit timing comes from the 8x-oversampled `baud` strobe of the baud generator. It sits between the project's message sources and the UART TX pin.

---
 rtl/uart_tx_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter plus 8N1 serialiser sharing one UART TX line.
//   clk   - single clock domain
//   rst   - synchronous, active-high reset
//   baud  - one-cycle strobe at OVS x bit rate
//   req   - per-requester level request, held until acked
//   data  - flattened bytes, requester i at [i*DATA_W +: DATA_W]
//   ack   - one-cycle one-hot pulse: byte of that requester was latched
//   owner - index of requester whose frame is in progress / was last sent
//   busy  - high while a frame is being sequenced
//   tx    - registered serial output, idle high
module uart_tx_sched #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_W-1:0]    data,
  output logic [NREQ-1:0]           ack,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      tx
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [TW-1:0]     tick, tick_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              tx_n;
  logic [NREQ-1:0]   ack_n;
  logic [PW-1:0]     owner_n;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic              wrap;

  // ptr holds the index searched first, i.e. last_granted+1 wrapped.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign wrap = baud && (tick == TW'(OVS - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    tick_n   = tick;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    tx_n     = tx;
    ack_n    = '0;
    owner_n  = owner;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (found) begin
          shift_n    = data[win*DATA_W +: DATA_W];
          owner_n    = win;
          ptr_n      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          ack_n[win] = 1'b1;
          state_n    = SYNC;
        end
      end
      // Entered on the capture edge, so a strobe coinciding with capture
      // is never seen here; the frame starts on the following strobe.
      SYNC: begin
        tx_n = 1'b1;
        if (baud) begin
          state_n = START;
          tick_n  = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud) tick_n = wrap ? '0 : tick + 1'b1;
        if (wrap) begin
          state_n  = DATA;
          bitcnt_n = '0;
          tx_n     = shift[0];
        end
      end
      DATA: begin
        if (baud) tick_n = wrap ? '0 : tick + 1'b1;
        if (wrap) begin
          shift_n  = shift >> 1;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BW'(DATA_W - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shift_n[0];
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud) tick_n = wrap ? '0 : tick + 1'b1;
        if (wrap) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      tick   <= '0;
      bitcnt <= '0;
      shift  <= '0;
      tx     <= 1'b1;
      ack    <= '0;
      owner  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      tick   <= tick_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      tx     <= tx_n;
      ack    <= ack_n;
      owner  <= owner_n;
    end
  end

endmodule
